inst_rom_cache: RTL and testbench

INST_ROM_CACHE -- requirements
Module: inst_rom_cache

---
 rtl/inst_mem_pkg.sv | 18 +
 rtl/inst_mem_if.sv | 79 +++++++
 rtl/inst_rom_cache.sv | 105 ++++++++++
 tb/tb_inst_rom_cache.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared FSM encoding and geometry helpers for the instruction ROM cache.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fetch_state_e;

  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/inst_mem_if.sv
// External read handshake for cache misses: latches the miss address,
// holds the request until ack, captures the returned word for the fill cycle.
module inst_mem_if
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_we,
  output logic              idle
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              unused_miss_bits;

  assign unused_miss_bits = ^miss_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
    end
  end

  // An ack outside REQ never reaches the fill register or the state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          addr_d  = {miss_addr[ADDR_W-1:2], 2'b00};
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_FILL;
          fill_d  = mem_rdata;
        end
      end
      ST_FILL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    fill_we = 1'b0;
    idle    = 1'b0;
    case (state_q)
      ST_IDLE: idle    = 1'b1;
      ST_REQ:  mem_req = 1'b1;
      ST_FILL: fill_we = 1'b1;
      default: idle    = 1'b1;
    endcase
  end

  assign mem_addr  = addr_q;
  assign fill_data = fill_q;

endmodule

// File: rtl/inst_rom_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of a ROM port.
// Lookup is combinational; misses go through inst_mem_if.
module inst_rom_cache
  import inst_mem_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] inst_address,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int IDX_W = calc_idx_w(LINES);
  localparam int TAG_W = calc_tag_w(ADDR_W, LINES);

  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_d;
  logic [DATA_W-1:0] data_d;

  logic [IDX_W-1:0]  lk_idx, fill_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              idle, start, fill_we;
  logic              unused_addr_bits;

  assign lk_idx   = inst_address[IDX_W+1:2];
  assign lk_tag   = inst_address[ADDR_W-1:IDX_W+2];
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign tag_d    = mem_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^inst_address[1:0];

  inst_mem_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_if (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .miss_addr (inst_address),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .fill_data (data_d),
    .fill_we   (fill_we),
    .idle      (idle)
  );

  // rst gates the outputs so they read zero while reset is held, whatever ce says.
  always_comb begin
    lk_hit     = ce & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    start      = idle & ce & ~lk_hit;
    inst_valid = rst & idle & lk_hit;
    stall      = rst & (~idle | (ce & ~lk_hit));
    inst       = inst_valid ? data_q[lk_idx] : '0;
  end

  // A flush seen while the request is outstanding makes the fill land invalid.
  always_comb begin
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if (fill_we) begin
      flush_pend_d = 1'b0;
    end else if (mem_req && flush) begin
      flush_pend_d = 1'b1;
    end
    if (flush) begin
      valid_d = '0;
    end else if (fill_we) begin
      valid_d[fill_idx] = ~flush_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= tag_d;
      data_q[fill_idx] <= data_d;
    end
  end

endmodule

// File: tb/tb_inst_rom_cache.sv
// Randomized and directed checks of inst_rom_cache against a line-level
// behavioural model; a responder plays the external ROM.
module tb_inst_rom_cache;

  localparam int LINES  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] inst_address;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  inst_rom_cache #(
    .LINES  (LINES),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .inst_address (inst_address),
    .flush        (flush),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: lines addressed by plain arithmetic
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  bit          m_req_pend, m_fill_pend, m_flush_seen;
  logic [31:0] m_addr, m_fill_val;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 4) % LINES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * LINES);
  endfunction

  function automatic bit model_hit();
    int l;
    l = line_of(inst_address);
    return (ce === 1'b1) && m_valid[l] && (m_tag[l] == tag_of(inst_address));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_req_pend   = 1'b0;
    m_fill_pend  = 1'b0;
    m_flush_seen = 1'b0;
    m_addr       = '0;
    m_fill_val   = '0;
  endtask

  task automatic model_step();
    int l;
    if (!(m_req_pend || m_fill_pend)) begin
      if (ce === 1'b1 && !model_hit()) begin
        m_req_pend   = 1'b1;
        m_addr       = inst_address & ~32'h3;
        m_flush_seen = 1'b0;
      end
    end else if (m_req_pend) begin
      if (flush === 1'b1) m_flush_seen = 1'b1;
      if (mem_ack === 1'b1) begin
        m_req_pend  = 1'b0;
        m_fill_pend = 1'b1;
        m_fill_val  = mem_rdata;
      end
    end else begin
      l = line_of(m_addr);
      m_tag[l]    = tag_of(m_addr);
      m_data[l]   = m_fill_val;
      m_valid[l]  = !(m_flush_seen || flush === 1'b1);
      m_fill_pend = 1'b0;
    end
    if (flush === 1'b1) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst === 1'b1) model_step();
  end

  task automatic check_output();
    logic [31:0] e_inst, e_addr;
    logic        e_iv, e_stall, e_req;
    e_inst  = '0;
    e_iv    = 1'b0;
    e_stall = 1'b0;
    e_req   = 1'b0;
    e_addr  = m_addr;
    if (rst === 1'b1) begin
      if (m_req_pend || m_fill_pend) begin
        e_stall = 1'b1;
        e_req   = m_req_pend;
      end else if (ce === 1'b1) begin
        if (model_hit()) begin
          e_iv   = 1'b1;
          e_inst = m_data[line_of(inst_address)];
        end else begin
          e_stall = 1'b1;
        end
      end
    end
    cmp("inst", inst, e_inst);
    cmp("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
    cmp("stall", {31'b0, stall}, {31'b0, e_stall});
    cmp("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    cmp("mem_addr", mem_addr, e_addr);
  endtask

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    #2;
    if (chk_en) check_output();
  end

  // ---------------- external ROM responder
  bit          auto_resp   = 1'b1;
  bit          spurious_en = 1'b0;
  bit          rand_delay  = 1'b0;
  int          ack_delay   = 2;
  int          req_cycles  = 0;
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always @(negedge clk) begin
    if (auto_resp) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (req_cycles == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end
      end else begin
        req_cycles = 0;
        if (rand_delay) ack_delay = $urandom_range(1, 4);
        if (spurious_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus tasks
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    cmp("reset_mem_req", {31'b0, mem_req}, 32'd0);
    cmp("reset_stall", {31'b0, stall}, 32'd0);
    cmp("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    cmp("reset_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit pulse_flush,
                       output int stalls, output int reqs,
                       output logic [31:0] got, output logic [31:0] req_addr);
    bit prev_req, done, flushed;
    stalls = 0; reqs = 0; got = '0; req_addr = '0;
    prev_req = 1'b0; done = 1'b0; flushed = 1'b0;
    @(negedge clk);
    ce = 1'b1;
    inst_address = a;
    flush = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (mem_req === 1'b1 && !prev_req) begin
        reqs++;
        if (reqs == 1) req_addr = mem_addr;
        if (pulse_flush && !flushed) begin
          flush = 1'b1;
          flushed = 1'b1;
        end
      end
      prev_req = (mem_req === 1'b1);
      if (inst_valid === 1'b1) begin
        got = inst;
        done = 1'b1;
      end else begin
        if (stall === 1'b1) stalls++;
        @(negedge clk);
        flush = 1'b0;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL fetch_timeout: addr=%h inst_valid never rose, required within 60 cycles", a);
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    ce = ($urandom_range(0, 9) < 8);
    if (stall !== 1'b1 || $urandom_range(0, 9) < 3) begin
      if ($urandom_range(0, 15) == 0)
        inst_address = $urandom;
      else
        inst_address = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    end
    flush = ($urandom_range(0, 39) == 0);
  endtask

  // ---------------- main sequence
  initial begin
    int          st, rq;
    logic [31:0] got, ra;
    rst = 1'b0;
    ce = 1'b0;
    flush = 1'b0;
    inst_address = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    model_reset();
    chk_en = 1'b1;
    do_reset();

    // first miss: ack on the second request cycle
    mem_img[32'h40] = 32'h2408_0001;
    ack_delay = 2;
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("first_miss_stall_cycles", st, 4);
    cmp("first_miss_inst", got, 32'h2408_0001);
    cmp("first_miss_mem_addr", ra, 32'h40);
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("repeat_hit_stalls", st, 0);
    cmp("repeat_hit_reqs", rq, 0);
    cmp("repeat_hit_inst", got, 32'h2408_0001);

    // aliasing: 0x40, 0x80 and 0x440 all map to line 0 with 16 lines
    do_reset();
    mem_img[32'h40]  = 32'h1111_1111;
    mem_img[32'h80]  = 32'h2222_2222;
    mem_img[32'h440] = 32'h3333_3333;
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("fill_0x40", got, 32'h1111_1111);
    fetch(32'h44, 1'b0, st, rq, got, ra);
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("other_line_keeps_0x40", rq, 0);
    fetch(32'h80, 1'b0, st, rq, got, ra);
    cmp("fill_0x80", got, 32'h2222_2222);
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("alias_0x80_evicted_0x40", rq, 1);
    fetch(32'h440, 1'b0, st, rq, got, ra);
    cmp("miss_0x440", rq, 1);
    cmp("fill_0x440", got, 32'h3333_3333);
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("0x440_evicted_0x40", rq, 1);

    // flush during REQ: fill lands invalid so the line is fetched twice
    ack_delay = 3;
    fetch(32'h100, 1'b1, st, rq, got, ra);
    cmp("flush_in_req_refetch", rq, 2);
    cmp("flush_in_req_inst", got, mem_word(32'h100));
    ack_delay = 2;

    // reset asserted mid-request
    fetch(32'h40, 1'b0, st, rq, got, ra);
    ack_delay = 20;
    @(negedge clk);
    ce = 1'b1;
    inst_address = 32'h200;
    for (int c = 0; c < 4 && mem_req !== 1'b1; c++) @(negedge clk);
    cmp("req_before_reset", {31'b0, mem_req}, 32'd1);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    cmp("reset_drops_mem_req", {31'b0, mem_req}, 32'd0);
    cmp("reset_drops_stall", {31'b0, stall}, 32'd0);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    ack_delay = 2;
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("after_reset_0x40_misses", rq, 1);

    // ack pulses with ce low change nothing
    auto_resp = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      cmp("ce_low_inst", inst, 32'd0);
      cmp("ce_low_inst_valid", {31'b0, inst_valid}, 32'd0);
      cmp("ce_low_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    auto_resp = 1'b1;
    fetch(32'h40, 1'b0, st, rq, got, ra);
    cmp("stray_ack_no_change_reqs", rq, 0);
    cmp("stray_ack_no_change_inst", got, 32'h1111_1111);

    // randomized traffic with variable latency, stray acks and flushes
    rand_delay = 1'b1;
    spurious_en = 1'b1;
    for (int n = 0; n < 2500; n++) apply_stimulus();
    @(negedge clk);
    flush = 1'b0;
    ce = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
